// File: rtl/keypad_scanner_if.sv
// Key-code handoff between the keypad scanner and the calculator core.
// Latency: none (signal bundle only).
// Backpressure: one-entry buffer; key_code is held while key_valid is high until key_ack.
interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (output key_code, key_valid, key_held, overrun, input key_ack);
    modport slave  (input key_code, key_valid, key_held, overrun, output key_ack);
endinterface

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces per frame, buffers one hex key code.
// Latency: accept is registered on the edge after the column-3 sample of the deciding frame.
// Backpressure: one-entry buffer; a new accept while full is dropped with a one-cycle overrun pulse.
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    keypad_scanner_if.master key
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] FRAMES     = CW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          sample;
    logic          frame_end;

    logic          acc_any;
    logic          acc_multi;
    logic [3:0]    acc_code;

    logic [3:0]    low;
    logic [2:0]    low_cnt;
    logic [1:0]    low_row;
    logic          tot_any;
    logic          tot_multi;
    logic [3:0]    tot_code;
    logic          is_none;
    logic          is_single;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    cand, cand_nxt;
    logic          accept;
    logic [3:0]    accept_code;

    assign sample    = (dwell == DWELL_LAST);
    assign frame_end = sample && (col_idx == 2'd3);

    // Dwell counter and column drive; the column register moves together with its index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell   <= '0;
            col_idx <= 2'd0;
            col     <= 4'b1110;
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= ~(4'b0001 << (col_idx + 2'd1));
        end else begin
            dwell   <= dwell + DW'(1);
        end
    end

    // Merge the current column's sample with the frame so far to classify NONE/SINGLE/MULTI.
    always_comb begin
        low     = ~row;
        low_cnt = 3'($countones(low));
        low_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (low[i]) low_row = 2'(i);
        end
        tot_any   = acc_any | (low_cnt != 3'd0);
        tot_multi = acc_multi | (low_cnt > 3'd1) | (acc_any & (low_cnt != 3'd0));
        tot_code  = acc_any ? acc_code : {low_row, col_idx};
        is_none   = !tot_any;
        is_single = tot_any & !tot_multi;
    end

    // Frame accumulator: collects columns 0..2, cleared once the frame has been judged.
    always_ff @(posedge clk) begin
        if (!rst_n || frame_end) begin
            acc_any   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'h0;
        end else if (sample) begin
            acc_any   <= tot_any;
            acc_multi <= tot_multi;
            acc_code  <= tot_code;
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            cand  <= 4'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    // Debounce next-state: one decision per frame; cnt doubles as the release counter.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cand_nxt    = cand;
        accept      = 1'b0;
        accept_code = cand;
        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (is_single) begin
                        cand_nxt = tot_code;
                        if (FRAMES == CW'(1)) begin
                            state_nxt   = S_PRESSED;
                            accept      = 1'b1;
                            accept_code = tot_code;
                            cnt_nxt     = '0;
                        end else begin
                            state_nxt = S_DEBOUNCE;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (is_single && (tot_code == cand)) begin
                        if (cnt + CW'(1) >= FRAMES) begin
                            state_nxt = S_PRESSED;
                            accept    = 1'b1;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else if (is_single) begin
                        cand_nxt = tot_code;
                        cnt_nxt  = CW'(1);
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                S_PRESSED: begin
                    if (is_none) begin
                        if (FRAMES == CW'(1)) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = S_RELEASE;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    if (is_none) begin
                        if (cnt + CW'(1) >= FRAMES) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else begin
                        state_nxt = S_PRESSED;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output buffer: an ack on the accept edge frees the slot so the new code loads without overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key.key_code  <= 4'h0;
            key.key_valid <= 1'b0;
            key.key_held  <= 1'b0;
            key.overrun   <= 1'b0;
        end else begin
            key.overrun  <= 1'b0;
            key.key_held <= (state_nxt == S_PRESSED) || (state_nxt == S_RELEASE);
            if (accept) begin
                if (!key.key_valid || key.key_ack) begin
                    key.key_code  <= accept_code;
                    key.key_valid <= 1'b1;
                end else begin
                    key.overrun <= 1'b1;
                end
            end else if (key.key_ack) begin
                key.key_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the seven-segment digit decoder. It scans a 4x4 active-low matrix keypad, debounces presses, and turns each accepted press into a 4-bit hex key code. Codes go to the calculator core through a one-entry valid/ack buffer. The block sits between the board keypad pins and the RPN entry logic; the core's hex digits return to the user through the existing nibble-to-segment decoder.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven (dwell). Must be ≥ 2.
- DEBOUNCE_FRAMES, 5: number of consecutive identical scan frames required to accept a press or a release. Must be ≥ 1.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  synchronous active-low reset, sampled on the CLK rising edge.
- ROW  input  4  keypad rows, active-low, externally pulled up, pre-synchronised.
- COL  output  4  keypad column drive, active-low, exactly one bit low at a time.
- KEY_CODE  output  4  buffered key code, `4*row + col`, 0x0..0xF.
- KEY_VALID  output  1  buffer full; KEY_CODE is stable while this is high.
- KEY_ACK  input  1  consumer acknowledge; effective only while KEY_VALID = 1.
- KEY_HELD  output  1  high while an accepted key is still physically held or releasing.
- OVERRUN  output  1  one-cycle pulse when an accepted key is dropped because the buffer is full.

## Operation
- Scan:
  - A dwell counter runs 0..SCAN_DIV-1.
  - A column index c runs 0→1→2→3→0 and advances when the dwell counter wraps.
  - COL = ~(4'b0001 << c).
  - ROW is sampled only at dwell count SCAN_DIV-1 (the settle window), for the current column.
- Frame: one frame is 4 columns. At the column-3 sample the frame is classified as:
  - NONE: no ROW bit low in any column.
  - SINGLE(code): exactly one low bit in exactly one column; code = {row[1:0], col[1:0]}.
  - MULTI: anything else.
- Debounce FSM, evaluated only at frame end:
  - IDLE:
    - SINGLE(k) → DEBOUNCE with cand = k, cnt = 1.
    - If DEBOUNCE_FRAMES = 1, go straight to PRESSED and accept k.
  - DEBOUNCE:
    - SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE_FRAMES, accept cand and go to PRESSED.
    - SINGLE(other) → restart DEBOUNCE with cand = other, cnt = 1.
    - NONE or MULTI → IDLE.
  - PRESSED:
    - NONE → RELEASE with rcnt = 1.
    - SINGLE or MULTI → stay. No new acceptance.
  - RELEASE:
    - NONE → rcnt+1. When rcnt reaches DEBOUNCE_FRAMES, go to IDLE.
    - Any press → PRESSED.
- Accept:
  - If KEY_VALID = 0, load KEY_CODE = cand and set KEY_VALID = 1.
  - Otherwise drop the key: KEY_CODE is unchanged and OVERRUN pulses.
- Ack: KEY_ACK = 1 while KEY_VALID = 1 clears KEY_VALID on the next edge. KEY_CODE holds its last value.
- Ack and accept in the same cycle: the new code loads, KEY_VALID stays 1, no OVERRUN.
- KEY_ACK while KEY_VALID = 0 is ignored.
- KEY_HELD = 1 in PRESSED and RELEASE; 0 otherwise.
- Holding a key never auto-repeats.

## Timing
- Reset values:
  - COL = 4'b1110.
  - Column index 0; dwell counter 0.
  - FSM in IDLE; cnt and rcnt 0.
  - KEY_CODE = 4'h0; KEY_VALID, KEY_HELD and OVERRUN = 0.
- Reset is honoured mid-scan, mid-debounce and with the buffer full; a pending code is discarded.
- All outputs are registered; no combinational path from ROW or KEY_ACK to any output.
- Frame period: 4*SCAN_DIV cycles. The frame-end decision occurs at the column-3 sample cycle; FSM and output updates are visible on the following edge.
- Press latency: a key stable from the start of a frame gives KEY_VALID high one cycle after the end of the DEBOUNCE_FRAMES-th frame.
- Release: KEY_HELD falls one cycle after the end of the DEBOUNCE_FRAMES-th consecutive NONE frame.
- OVERRUN is high for exactly one cycle, coincident with the would-be accept edge.
- COL changes one cycle after the dwell wrap. COL is never all-high or multi-low.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_FRAMES=3 (frame = 16 cycles).
- Reset: drive RST_N=0 for 1 cycle mid-frame with a key held → COL=1110, KEY_VALID=0, KEY_CODE=0, KEY_HELD=0. Scan restarts at column 0.
- Single press, row 2 col 1, held 10 frames → KEY_VALID rises 1 cycle after frame 3 with KEY_CODE=0x9; stays high with KEY_ACK=0; KEY_ACK pulse clears it next cycle; no second VALID while held. After release, KEY_HELD falls 3 frames later.
- Bounce: row 0 col 3 present 2 frames, absent 1 frame, present 4 frames → exactly one VALID with code 0x3, at the 3rd frame of the second burst.
- Ghost/multi: row 0 col 0 plus row 0 col 3 held 8 frames → no VALID, no OVERRUN, KEY_HELD=0.
- Overrun: accept 0x5, leave unacked, release, then press 0xA → OVERRUN high 1 cycle, KEY_CODE stays 0x5, KEY_VALID stays 1.
- Ack collision: with 0x5 pending, assert KEY_ACK exactly on the accept edge of 0xC → KEY_VALID stays 1, KEY_CODE=0xC, OVERRUN=0.
